// File: rtl/sram_master.sv
`default_nettype none
// ============================================================================
// Module   : sram_master
// Purpose  : Single/burst read-write initiator for an sram_slave1 style port.
// Revision : 1.0 - initial release
// ============================================================================
module sram_master #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int LW     = 4,
  parameter int RD_LAT = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] saddr,
  output logic [DW-1:0] sdatain,
  output logic          SWRITE,
  input  logic [DW-1:0] srdataout
);

  localparam logic [2:0] c_RD_LAT = 3'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RD_RESP  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_cnt;
  logic [2:0]    r_lat;
  logic          w_last;
  logic          w_rd_cap;
  logic          w_rd_hs;

  // r_cnt holds beats remaining minus one, so zero marks the final beat
  assign w_last    = (r_cnt == '0);
  assign w_rd_cap  = (r_state == S_RD_WAIT) && (r_lat == c_RD_LAT);
  assign w_rd_hs   = (r_state == S_RD_RESP) && rd_ready;
  assign cmd_ready = (r_state == S_IDLE);
  assign wr_ready  = (r_state == S_WR);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (cmd_valid) w_next = cmd_write ? S_WR : S_RD_ISSUE;
      S_WR:       if (wr_valid && w_last) w_next = S_IDLE;
      S_RD_ISSUE: w_next = S_RD_WAIT;
      S_RD_WAIT:  if (w_rd_cap) w_next = S_RD_RESP;
      S_RD_RESP:  if (w_rd_hs) w_next = w_last ? S_IDLE : S_RD_ISSUE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr   <= '0;
      r_cnt    <= '0;
      r_lat    <= '0;
      saddr    <= '0;
      sdatain  <= '0;
      SWRITE   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
    end else begin
      SWRITE <= 1'b0;
      done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr <= cmd_addr;
            r_cnt  <= cmd_len;
          end
        end
        S_WR: begin
          if (wr_valid) begin
            saddr   <= r_addr;
            sdatain <= wr_data;
            SWRITE  <= 1'b1;
            r_addr  <= r_addr + AW'(1);
            r_cnt   <= r_cnt - LW'(1);
            done    <= w_last;
          end
        end
        S_RD_ISSUE: begin
          saddr <= r_addr;
          r_lat <= '0;
        end
        S_RD_WAIT: begin
          // saddr is held here so the slave sees a stable address for the whole latency
          if (w_rd_cap) begin
            rd_data  <= srdataout;
            rd_valid <= 1'b1;
          end else begin
            r_lat <= r_lat + 3'd1;
          end
        end
        S_RD_RESP: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            r_addr   <= r_addr + AW'(1);
            r_cnt    <= r_cnt - LW'(1);
            done     <= w_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_master
// Purpose  : Checks sram_master (RD_LAT 0 and 1) against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_master;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic       cmd_valid [N], cmd_ready [N], cmd_write [N];
  logic       wr_valid [N], wr_ready [N], rd_valid [N], rd_ready [N];
  logic       busy [N], done [N], SWRITE [N];
  logic [7:0] cmd_addr [N], wr_data [N], rd_data [N], saddr [N], sdatain [N], srdataout [N];
  logic [3:0] cmd_len [N];

  sram_master #(.AW(8), .DW(8), .LW(4), .RD_LAT(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_len(cmd_len[0]),
    .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_data(wr_data[0]),
    .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]), .rd_data(rd_data[0]),
    .busy(busy[0]), .done(done[0]), .saddr(saddr[0]), .sdatain(sdatain[0]),
    .SWRITE(SWRITE[0]), .srdataout(srdataout[0]));

  sram_master #(.AW(8), .DW(8), .LW(4), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_len(cmd_len[1]),
    .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_data(wr_data[1]),
    .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]), .rd_data(rd_data[1]),
    .busy(busy[1]), .done(done[1]), .saddr(saddr[1]), .sdatain(sdatain[1]),
    .SWRITE(SWRITE[1]), .srdataout(srdataout[1]));

  // Slave stand-ins: instance 0 reads combinationally, instance 1 through a register
  logic       mem_init;
  logic [7:0] smem [N][256];
  logic [7:0] rdq1;
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (mem_init) for (int i = 0; i < 256; i++) smem[k][i] <= 8'(i) ^ 8'h5A;
      else if (SWRITE[k]) smem[k][saddr[k]] <= sdatain[k];
    end
    rdq1 <= smem[1][saddr[1]];
  end
  assign srdataout[0] = smem[0][saddr[0]];
  assign srdataout[1] = rdq1;

  int n_checks = 0;
  int n_fail   = 0;
  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Transaction model: per command it walks the address, counts beats, and
  // predicts the slave write and read-return timing from the read latency.
  logic       e_busy [N], e_write [N], e_rvalid [N], e_sw [N], e_done [N];
  logic [7:0] e_addr [N], e_rdata [N], e_sa [N], e_sd [N];
  int         e_left [N], e_rcnt [N];
  logic [7:0] rm [N][256];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < N; k++) begin
        e_busy[k] <= 1'b0; e_write[k] <= 1'b0; e_rvalid[k] <= 1'b0;
        e_sw[k] <= 1'b0; e_done[k] <= 1'b0; e_addr[k] <= 8'h00;
        e_rdata[k] <= 8'h00; e_sa[k] <= 8'h00; e_sd[k] <= 8'h00;
        e_left[k] <= 0; e_rcnt[k] <= 0;
        if (mem_init) for (int i = 0; i < 256; i++) rm[k][i] <= 8'(i) ^ 8'h5A;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        e_sw[k]   <= 1'b0;
        e_done[k] <= 1'b0;
        if (e_sw[k]) rm[k][e_sa[k]] <= e_sd[k];
        if (!e_busy[k]) begin
          if (cmd_valid[k]) begin
            e_busy[k]  <= 1'b1;
            e_write[k] <= cmd_write[k];
            e_addr[k]  <= cmd_addr[k];
            e_left[k]  <= int'(cmd_len[k]) + 1;
            e_rcnt[k]  <= 2 + k;  // instance index equals its read latency
          end
        end else if (e_write[k]) begin
          if (wr_valid[k]) begin
            e_sw[k]   <= 1'b1;
            e_sa[k]   <= e_addr[k];
            e_sd[k]   <= wr_data[k];
            e_addr[k] <= e_addr[k] + 8'd1;
            e_left[k] <= e_left[k] - 1;
            if (e_left[k] == 1) begin e_busy[k] <= 1'b0; e_done[k] <= 1'b1; end
          end
        end else if (e_rvalid[k]) begin
          if (rd_ready[k]) begin
            e_rvalid[k] <= 1'b0;
            e_addr[k]   <= e_addr[k] + 8'd1;
            e_left[k]   <= e_left[k] - 1;
            if (e_left[k] == 1) begin e_busy[k] <= 1'b0; e_done[k] <= 1'b1; end
            else e_rcnt[k] <= 2 + k;
          end
        end else if (e_rcnt[k] == 1) begin
          e_rvalid[k] <= 1'b1;
          e_rdata[k]  <= rm[k][e_addr[k]];
        end else begin
          e_rcnt[k] <= e_rcnt[k] - 1;
        end
      end
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        check("cmd_ready", k, cmd_ready[k], !e_busy[k]);
        check("wr_ready", k, wr_ready[k], e_busy[k] && e_write[k]);
        check("busy", k, busy[k], e_busy[k]);
        check("rd_valid", k, rd_valid[k], e_rvalid[k]);
        check("SWRITE", k, SWRITE[k], e_sw[k]);
        check("done", k, done[k], e_done[k]);
        if (e_sw[k]) begin
          check("saddr", k, saddr[k], e_sa[k]);
          check("sdatain", k, sdatain[k], e_sd[k]);
        end
        if (e_rvalid[k]) check("rd_data", k, rd_data[k], e_rdata[k]);
        if (!rstn) begin
          check("rst_saddr", k, saddr[k], 0);
          check("rst_sdatain", k, sdatain[k], 0);
          check("rst_rd_data", k, rd_data[k], 0);
        end
      end
    end
  end

  // Event logs for the directed literal checks
  int         cyc = 0;
  logic [15:0] wlog [N][$];
  int         wcyc [N][$];
  logic [7:0] got [N][$];
  int         rcyc [N][$];
  int         acyc [N];
  int         dcnt [N];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < N; k++) begin
      if (mem_init) begin acyc[k] <= 0; dcnt[k] <= 0; end
      else if (rstn) begin
        if (SWRITE[k]) begin wlog[k].push_back({saddr[k], sdatain[k]}); wcyc[k].push_back(cyc); end
        if (rd_valid[k] && rd_ready[k]) begin got[k].push_back(rd_data[k]); rcyc[k].push_back(cyc); end
        if (cmd_valid[k] && cmd_ready[k]) acyc[k] <= cyc;
        if (done[k]) dcnt[k] <= dcnt[k] + 1;
      end
    end
  end

  task automatic clear_logs(input int k);
    wlog[k].delete(); wcyc[k].delete(); got[k].delete(); rcyc[k].delete();
  endtask

  task automatic send_cmd(input int k, input logic w, input logic [7:0] a, input logic [3:0] l);
    int t = 0;
    cmd_valid[k] = 1'b1; cmd_write[k] = w; cmd_addr[k] = a; cmd_len[k] = l;
    @(negedge clk);
    while (!cmd_ready[k] && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("cmd_timeout", k, 0, 1);
    @(posedge clk); #1;
    cmd_valid[k] = 1'b0;
  endtask

  task automatic write_beats(input int k, input logic [7:0] d[$], input int gap_at);
    int t;
    for (int i = 0; i < d.size(); i++) begin
      if (i == gap_at) begin
        wr_valid[k] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      wr_valid[k] = 1'b1; wr_data[k] = d[i];
      t = 0;
      @(negedge clk);
      while (!wr_ready[k] && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) check("wr_timeout", k, 0, 1);
      @(posedge clk); #1;
    end
    wr_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int t = 0;
    @(negedge clk);
    while (busy[k] && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("idle_timeout", k, 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [7:0] wq [$];
  logic [7:0] pat [4];
  int         d0;

  initial begin
    for (int k = 0; k < N; k++) begin
      cmd_valid[k] = 1'b1; cmd_write[k] = 1'b0; cmd_addr[k] = 8'h00; cmd_len[k] = 4'h0;
      wr_valid[k] = 1'b0; wr_data[k] = 8'h00; rd_ready[k] = 1'b1;
    end
    rstn = 1'b0; mem_init = 1'b1;
    repeat (3) @(posedge clk);
    #1; mem_init = 1'b0; chk_en = 1'b1;

    // 1: reset held with cmd_valid asserted
    @(negedge clk);
    check("t1_cmd_ready", 0, cmd_ready[0], 1);
    check("t1_outputs", 0, {busy[0], wr_ready[0], rd_valid[0], done[0], SWRITE[0]}, 0);
    check("t1_saddr_sdatain", 0, {saddr[0], sdatain[0], rd_data[0]}, 0);
    cmd_valid[0] = 1'b0; cmd_valid[1] = 1'b0;
    @(posedge clk); #1; rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t1_no_write", 0, wlog[0].size(), 0);

    // 2: single write then single read
    clear_logs(0); d0 = dcnt[0];
    send_cmd(0, 1'b1, 8'h10, 4'd0);
    wq = '{8'hA5};
    write_beats(0, wq, -1);
    wait_idle(0);
    check("t2_wr_count", 0, wlog[0].size(), 1);
    if (wlog[0].size() > 0) check("t2_wr_beat", 0, wlog[0][0], 16'h10A5);
    check("t2_done_wr", 0, dcnt[0] - d0, 1);
    send_cmd(0, 1'b0, 8'h10, 4'd0);
    wait_idle(0);
    check("t2_rd_count", 0, got[0].size(), 1);
    if (got[0].size() > 0) check("t2_rd_data", 0, got[0][0], 8'hA5);
    check("t2_done_rd", 0, dcnt[0] - d0, 2);

    // 3: wrapping burst FE..01, back to back, then read back
    clear_logs(0); d0 = dcnt[0];
    pat = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_cmd(0, 1'b1, 8'hFE, 4'd3);
    wq = '{8'h11, 8'h22, 8'h33, 8'h44};
    write_beats(0, wq, -1);
    wait_idle(0);
    check("t3_wr_count", 0, wlog[0].size(), 4);
    for (int i = 0; i < 4 && i < wlog[0].size(); i++) begin
      check("t3_wr_beat", 0, wlog[0][i], {8'(8'hFE + i), pat[i]});
      check("t3_wr_consecutive", 0, wcyc[0][i] - wcyc[0][0], i);
    end
    send_cmd(0, 1'b0, 8'hFE, 4'd3);
    wait_idle(0);
    check("t3_rd_count", 0, got[0].size(), 4);
    for (int i = 0; i < 4 && i < got[0].size(); i++) check("t3_rd_data", 0, got[0][i], pat[i]);
    if (rcyc[0].size() == 4) begin
      check("t3_rd_first_lat", 0, rcyc[0][0] - acyc[0], 3);
      check("t3_rd_period", 0, rcyc[0][3] - rcyc[0][2], 3);
    end
    check("t3_done", 0, dcnt[0] - d0, 2);

    // 4: write gap of two cycles, then read held off for three cycles
    clear_logs(0);
    send_cmd(0, 1'b1, 8'h30, 4'd3);
    wq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    write_beats(0, wq, 2);
    wait_idle(0);
    check("t4_wr_count", 0, wlog[0].size(), 4);
    if (wlog[0].size() == 4) begin
      check("t4_gap", 0, wcyc[0][2] - wcyc[0][1], 3);
      check("t4_after_gap", 0, wlog[0][2], 16'h32C3);
    end
    rd_ready[0] = 1'b0;
    send_cmd(0, 1'b0, 8'h30, 4'd1);
    begin
      int t = 0;
      @(negedge clk);
      while (!rd_valid[0] && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) check("t4_rd_timeout", 0, 0, 1);
    end
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_data", 0, rd_data[0], 8'hC1);
      check("t4_hold_saddr", 0, saddr[0], 8'h30);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1; rd_ready[0] = 1'b1;
    wait_idle(0);
    check("t4_rd_count", 0, got[0].size(), 2);
    if (got[0].size() == 2) check("t4_rd_data", 0, {got[0][0], got[0][1]}, 16'hC1C2);

    // 5: reset after the second beat has been written
    clear_logs(0); d0 = dcnt[0];
    send_cmd(0, 1'b1, 8'h20, 4'd3);
    wr_valid[0] = 1'b1; wr_data[0] = 8'h01;
    @(posedge clk); #1; wr_data[0] = 8'h02;
    @(posedge clk); #1; wr_data[0] = 8'h03;
    @(posedge clk); #1; rstn = 1'b0;
    #1;
    check("t5_swrite_drop", 0, SWRITE[0], 0);
    check("t5_busy_drop", 0, busy[0], 0);
    wr_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1; rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t5_mem20", 0, smem[0][8'h20], 8'h01);
    check("t5_mem21", 0, smem[0][8'h21], 8'h02);
    check("t5_mem22", 0, smem[0][8'h22], 8'h78);
    check("t5_mem23", 0, smem[0][8'h23], 8'h79);
    check("t5_no_done", 0, dcnt[0] - d0, 0);
    check("t5_wr_count", 0, wlog[0].size(), 2);

    // 6: registered-read slave
    clear_logs(1);
    send_cmd(1, 1'b1, 8'h40, 4'd1);
    wq = '{8'h5C, 8'hC5};
    write_beats(1, wq, -1);
    wait_idle(1);
    send_cmd(1, 1'b0, 8'h40, 4'd1);
    wait_idle(1);
    check("t6_rd_count", 1, got[1].size(), 2);
    if (got[1].size() == 2) begin
      check("t6_rd_data", 1, {got[1][0], got[1][1]}, 16'h5CC5);
      check("t6_rd_first_lat", 1, rcyc[1][0] - acyc[1], 4);
      check("t6_rd_period", 1, rcyc[1][1] - rcyc[1][0], 4);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
